// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 16;

    typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// registered read port whose output holds when no read is requested.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage write port.
    // NOTE: the array has no reset on purpose; clearing it would turn every
    // entry into a resettable flop for no functional gain, since the pointers
    // and count already define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port: captures the addressed word on an accepted read.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrapping read/write pointers, an occupancy counter,
// accept logic and full/empty flags decoded from the registered count.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = FIFO_DATA_WIDTH,
    parameter int DEPTH          = FIFO_DEPTH,
    parameter bit PROTOCOL_CHECK = 1'b0,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_rd_acc;
    logic          w_wr_acc;

    // Flags and accept decisions; a full FIFO still takes a write when a read
    // frees a slot on the same edge, an empty FIFO never bypasses.
    always_comb begin
        full     = (r_count == FULL_COUNT);
        empty    = (r_count == '0);
        w_rd_acc = rd_en && !empty;
        w_wr_acc = wr_en && (!full || w_rd_acc);
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (data_out)
    );

    // Optional producer/consumer protocol checks; the FIFO itself tolerates
    // violations, so these only flag misbehaving neighbours.
    if (PROTOCOL_CHECK) begin : g_protocol
        a_no_write_when_full: assert property (
            @(posedge clk) disable iff (!rst_n) full |-> !wr_en);
        a_no_read_when_empty: assert property (
            @(posedge clk) disable iff (!rst_n) empty |-> !rd_en);
    end

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo.
module tb_sync_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    fifo_data_t data_in = '0;
    fifo_data_t data_out;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo #(
        .DATA_WIDTH     (FIFO_DATA_WIDTH),
        .DEPTH          (FIFO_DEPTH),
        .PROTOCOL_CHECK (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive request, let the edge happen, sample 1 ns later.
    task automatic cycle(input logic wr, input logic rd, input fifo_data_t din);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        fifo_data_t basic [5];
        basic = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};

        // Reset
        #12;
        check("rst_empty", {7'd0, empty}, 8'd1);
        check("rst_full", {7'd0, full}, 8'd0);
        check("rst_dout", data_out, 8'h00);
        rst_n = 1'b1;

        // Basic order
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, basic[i]);
        check("basic_not_empty", {7'd0, empty}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("basic_rd%0d", i), data_out, basic[i]);
        end
        check("basic_empty_after", {7'd0, empty}, 8'd1);

        // Fill to full, dropped 17th write
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            if (i == 14) check("fill_full_at15", {7'd0, full}, 8'd0);
        end
        check("fill_full_at16", {7'd0, full}, 8'd1);
        cycle(1'b1, 1'b0, 8'hEE);
        check("drop_full_held", {7'd0, full}, 8'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("fill_rd%0d", i), data_out, 8'(i));
        end
        check("fill_empty_after", {7'd0, empty}, 8'd1);
        cycle(1'b0, 1'b1, '0);
        check("rd_empty_ignored", data_out, 8'h0F);

        // Wrap-around: advance pointers by 10, then a full batch crosses the wrap
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("adv_rd%0d", i), data_out, 8'(8'h20 + i));
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h40 + i));
            check($sformatf("wrap_full%0d", i), {7'd0, full}, (i == 15) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("wrap_rd%0d", i), data_out, 8'(8'h40 + i));
        end
        check("wrap_empty_after", {7'd0, empty}, 8'd1);

        // Simultaneous read+write while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        check("simf_full_before", {7'd0, full}, 8'd1);
        cycle(1'b1, 1'b1, 8'h99);
        check("simf_oldest", data_out, 8'h60);
        check("simf_full_kept", {7'd0, full}, 8'd1);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("simf_rd%0d", i), data_out, 8'(8'h60 + i));
        end
        cycle(1'b0, 1'b1, '0);
        check("simf_last_99", data_out, 8'h99);
        check("simf_empty_after", {7'd0, empty}, 8'd1);

        // Simultaneous read+write while empty
        cycle(1'b1, 1'b1, 8'h77);
        check("sime_dout_held", data_out, 8'h99);
        check("sime_not_empty", {7'd0, empty}, 8'd0);
        cycle(1'b0, 1'b1, '0);
        check("sime_rd77", data_out, 8'h77);
        check("sime_empty_after", {7'd0, empty}, 8'd1);

        // Asynchronous reset mid-stream
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b1, 1'b0, 8'h33);
        check("arst_not_empty", {7'd0, empty}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty_now", {7'd0, empty}, 8'd1);
        check("arst_full_now", {7'd0, full}, 8'd0);
        check("arst_dout_now", data_out, 8'h00);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, '0);
        check("arst_rd_ignored", data_out, 8'h00);
        check("arst_rd_empty", {7'd0, empty}, 8'd1);
        cycle(1'b1, 1'b0, 8'h55);
        cycle(1'b0, 1'b1, '0);
        check("arst_post_rd", data_out, 8'h55);
        check("arst_post_empty", {7'd0, empty}, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo
